// File: rtl/vc_dest_arbiter_pkg.sv
// Shared transaction-layer definitions for the VC-to-destination scheduler.
package vc_dest_arbiter_pkg;

    // Default head-word width and position of the destination select bit.
    localparam int unsigned DefDataW  = 6;
    localparam int unsigned DefDestBit = 4;

    // One-hot state encoding shared with the transaction FSM.
    typedef enum logic [3:0] {
        StDisabled = 4'b0001,
        StRun      = 4'b0010,
        StStalled  = 4'b0100,
        StError    = 4'b1000
    } arb_state_e;

endpackage

// File: rtl/vc_dest_arbiter_if.sv
// Handshake bundle between the VC FIFOs, destination FIFOs and the scheduler.
interface vc_dest_arbiter_if
    import vc_dest_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned CNT_W  = 8
);
    logic              enable;
    logic              vc0_empty;
    logic              vc1_empty;
    logic [DATA_W-1:0] vc0_data;
    logic [DATA_W-1:0] vc1_data;
    logic              d0_almost_full;
    logic              d1_almost_full;
    logic              pop_vc0;
    logic              pop_vc1;
    logic              push_d0;
    logic              push_d1;
    logic [DATA_W-1:0] data_out;
    logic              active_out;
    logic              idle_out;
    logic              stall_err;
    logic [CNT_W-1:0]  xfer_cnt;

    // FIFO / FSM side: drives status and head words, consumes pops and pushes.
    modport master (
        output enable, vc0_empty, vc1_empty, vc0_data, vc1_data,
        output d0_almost_full, d1_almost_full,
        input  pop_vc0, pop_vc1, push_d0, push_d1, data_out,
        input  active_out, idle_out, stall_err, xfer_cnt
    );

    // Scheduler side.
    modport slave (
        input  enable, vc0_empty, vc1_empty, vc0_data, vc1_data,
        input  d0_almost_full, d1_almost_full,
        output pop_vc0, pop_vc1, push_d0, push_d1, data_out,
        output active_out, idle_out, stall_err, xfer_cnt
    );

endinterface

// File: rtl/vc_dest_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; a tie goes to the requester not granted last.
module vc_dest_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    logic last_q;

    // Grant decode: single requester wins outright, a tie alternates.
    always_comb begin
        gnt_o     = 2'b00;
        gnt_idx_o = 1'b0;
        unique case (req_i)
            2'b01: gnt_o = 2'b01;
            2'b10: begin
                gnt_o     = 2'b10;
                gnt_idx_o = 1'b1;
            end
            2'b11: begin
                if (last_q) begin
                    gnt_o = 2'b01;
                end else begin
                    gnt_o     = 2'b10;
                    gnt_idx_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Remember the winner; reset value 1 lets requester 0 take the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (|gnt_o) begin
            last_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/vc_dest_arbiter.sv
// Moves one VC head word per cycle into the destination FIFO its dest bit selects,
// with round-robin between VCs, almost-full back-pressure and a stall watchdog.
module vc_dest_arbiter
    import vc_dest_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned DEST_BIT  = DefDestBit,
    parameter int unsigned STALL_MAX = 15,
    parameter int unsigned CNT_W     = 8
) (
    input logic               clk,
    input logic               reset,
    vc_dest_arbiter_if.slave  bus
);

    localparam int unsigned StallW = $clog2(STALL_MAX + 1);

    arb_state_e        state_q;
    logic [StallW-1:0] stall_cnt_q;
    logic              stall_err_q;
    logic [CNT_W-1:0]  xfer_cnt_q;

    logic              dest0, dest1;
    logic              blk0, blk1;
    logic              can_run;
    logic              any_pending;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              gnt_idx;
    logic              gnt_valid;
    logic              gnt_dest;
    logic [DATA_W-1:0] gnt_word;

    assign dest0       = bus.vc0_data[DEST_BIT];
    assign dest1       = bus.vc1_data[DEST_BIT];
    assign any_pending = ~bus.vc0_empty | ~bus.vc1_empty;

    // Eligibility: only in RUN/STALLED, and never while reset is held so no word
    // is popped in a cycle whose FIFO update would be discarded.
    always_comb begin
        blk0    = dest0 ? bus.d1_almost_full : bus.d0_almost_full;
        blk1    = dest1 ? bus.d1_almost_full : bus.d0_almost_full;
        can_run = ~reset & bus.enable & ((state_q == StRun) | (state_q == StStalled));
        req[0]  = can_run & ~bus.vc0_empty & ~blk0;
        req[1]  = can_run & ~bus.vc1_empty & ~blk1;
    end

    vc_dest_arbiter_rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // Cut-through routing of the granted head word.
    always_comb begin
        gnt_valid = |gnt;
        gnt_word  = gnt_idx ? bus.vc1_data : bus.vc0_data;
        gnt_dest  = gnt_idx ? dest1 : dest0;
    end

    assign bus.pop_vc0    = gnt[0];
    assign bus.pop_vc1    = gnt[1];
    assign bus.push_d0    = gnt_valid & ~gnt_dest;
    assign bus.push_d1    = gnt_valid & gnt_dest;
    assign bus.data_out   = gnt_valid ? gnt_word : '0;
    assign bus.active_out = gnt_valid;
    assign bus.idle_out   = ~reset & bus.enable & bus.vc0_empty & bus.vc1_empty &
                            (state_q != StError);
    assign bus.stall_err  = stall_err_q;
    assign bus.xfer_cnt   = xfer_cnt_q;

    // Scheduler FSM with stall watchdog; ERROR is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StDisabled;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else if (state_q != StError) begin
            if (!bus.enable) begin
                state_q     <= StDisabled;
                stall_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StDisabled: begin
                        state_q     <= StRun;
                        stall_cnt_q <= '0;
                    end
                    StRun: begin
                        // The RUN cycle that blocked already counts as one stalled cycle.
                        if (any_pending && !gnt_valid) begin
                            state_q     <= StStalled;
                            stall_cnt_q <= StallW'(1);
                        end
                    end
                    StStalled: begin
                        if (gnt_valid || !any_pending) begin
                            state_q     <= StRun;
                            stall_cnt_q <= '0;
                        end else if (stall_cnt_q == StallW'(STALL_MAX - 1)) begin
                            state_q     <= StError;
                            stall_err_q <= 1'b1;
                        end else if (stall_cnt_q != '1) begin
                            stall_cnt_q <= stall_cnt_q + StallW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Transfer counter, wraps modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_cnt_q <= '0;
        end else if (gnt_valid) begin
            xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Scoreboard bench for vc_dest_arbiter: directed scenarios plus random traffic,
// checked against a cycle-level reference model of the scheduling rules.
module tb_vc_dest_arbiter;
    import vc_dest_arbiter_pkg::*;

    localparam int unsigned DW   = 6;
    localparam int unsigned DB   = 4;
    localparam int unsigned SMAX = 15;
    localparam int unsigned CW   = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vc_dest_arbiter_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    vc_dest_arbiter #(
        .DATA_W    (DW),
        .DEST_BIT  (DB),
        .STALL_MAX (SMAX),
        .CNT_W     (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic          active;
        logic          idle;
        logic          err;
        logic [CW-1:0] cnt;
    } cyc_exp_t;

    typedef struct packed {
        logic [1:0]    pop;
        logic [1:0]    push;
        logic [DW-1:0] data;
    } xfer_t;

    cyc_exp_t cq[$];
    xfer_t    xq[$];
    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit m_last    = 1'b1;
    bit m_err     = 1'b0;
    bit m_armed   = 1'b0;
    int m_blocked = 0;
    int m_xfer    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, push the model's expectation, advance the model.
    task automatic cyc(input bit rst, input bit en, input bit e0, input bit e1,
                       input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                       input bit af0, input bit af1);
        bit ok, el0, el1, dst;
        int g;
        xfer_t x;
        cyc_exp_t c;
        @(negedge clk);
        reset              = rst;
        bus.enable         = en;
        bus.vc0_empty      = e0;
        bus.vc1_empty      = e1;
        bus.vc0_data       = w0;
        bus.vc1_data       = w1;
        bus.d0_almost_full = af0;
        bus.d1_almost_full = af1;

        ok  = !rst && en && m_armed && !m_err;
        el0 = ok && !e0 && !(w0[DB] ? af1 : af0);
        el1 = ok && !e1 && !(w1[DB] ? af1 : af0);
        if (el0 && el1) g = m_last ? 0 : 1;
        else if (el0)   g = 0;
        else if (el1)   g = 1;
        else            g = -1;

        c.active = (g >= 0);
        c.idle   = !rst && en && e0 && e1 && !m_err;
        c.err    = m_err;
        c.cnt    = CW'(m_xfer);
        cq.push_back(c);
        if (g >= 0) begin
            dst    = (g == 1) ? w1[DB] : w0[DB];
            x.pop  = (g == 1) ? 2'b10 : 2'b01;
            x.push = dst ? 2'b10 : 2'b01;
            x.data = (g == 1) ? w1 : w0;
            xq.push_back(x);
        end

        if (rst) begin
            m_last    = 1'b1;
            m_err     = 1'b0;
            m_armed   = 1'b0;
            m_blocked = 0;
            m_xfer    = 0;
        end else begin
            if (g >= 0) begin
                m_last = (g == 1);
                m_xfer = (m_xfer + 1) % (1 << CW);
            end
            if (!m_err) begin
                // Consecutive enabled cycles with work pending but nothing moved.
                if (m_armed && en && (!e0 || !e1) && g < 0) begin
                    m_blocked++;
                    if (m_blocked >= SMAX) m_err = 1'b1;
                end else begin
                    m_blocked = 0;
                end
            end
            m_armed = en;
        end
    endtask

    // Monitor: status every cycle, transfer contents whenever the DUT moves a word.
    initial begin
        cyc_exp_t e;
        xfer_t x;
        forever begin
            @(negedge clk);
            #2;
            if (cq.size() > 0) begin
                e = cq.pop_front();
                check("active_out", 32'(bus.active_out), 32'(e.active));
                check("idle_out", 32'(bus.idle_out), 32'(e.idle));
                check("stall_err", 32'(bus.stall_err), 32'(e.err));
                check("xfer_cnt", 32'(bus.xfer_cnt), 32'(e.cnt));
                if (bus.active_out === 1'b1) begin
                    if (xq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got data %0h expected none at %0t",
                                 bus.data_out, $time);
                    end else begin
                        x = xq.pop_front();
                        check("pop", 32'({bus.pop_vc1, bus.pop_vc0}), 32'(x.pop));
                        check("push", 32'({bus.push_d1, bus.push_d0}), 32'(x.push));
                        check("data_out", 32'(bus.data_out), 32'(x.data));
                    end
                end else begin
                    check("pop_idle", 32'({bus.pop_vc1, bus.pop_vc0}), 32'd0);
                    check("push_idle", 32'({bus.push_d1, bus.push_d0}), 32'd0);
                    check("data_idle", 32'(bus.data_out), 32'd0);
                end
            end
        end
    end

    initial begin
        bus.enable         = 1'b0;
        bus.vc0_empty      = 1'b1;
        bus.vc1_empty      = 1'b1;
        bus.vc0_data       = '0;
        bus.vc1_data       = '0;
        bus.d0_almost_full = 1'b0;
        bus.d1_almost_full = 1'b0;

        // Reset, then enable with nothing queued.
        repeat (2) cyc(1, 0, 1, 1, 6'h00, 6'h00, 0, 0);
        cyc(0, 0, 1, 1, 6'h00, 6'h00, 0, 0);
        cyc(0, 1, 1, 1, 6'h00, 6'h00, 0, 0);
        // Single VC0 word to D0.
        cyc(0, 1, 0, 1, 6'h05, 6'h00, 0, 0);
        cyc(0, 1, 1, 1, 6'h00, 6'h00, 0, 0);
        // Both VCs, different destinations: alternation.
        repeat (4) cyc(0, 1, 0, 0, 6'h03, 6'h1A, 0, 0);
        // VC0 blocked on D1, VC1 to D0 keeps flowing.
        repeat (4) cyc(0, 1, 0, 0, 6'h11, 6'h02, 0, 1);
        // Enable drop mid-stream, then resume.
        repeat (2) cyc(0, 0, 0, 0, 6'h03, 6'h1A, 0, 0);
        repeat (4) cyc(0, 1, 0, 0, 6'h03, 6'h1A, 0, 0);
        // Both heads to a full D0: stall, then sticky error.
        repeat (17) cyc(0, 1, 0, 0, 6'h01, 6'h07, 1, 0);
        repeat (4) cyc(0, 1, 0, 0, 6'h01, 6'h07, 0, 0);
        // Recover, then reset during a grant cycle.
        cyc(1, 1, 1, 1, 6'h00, 6'h00, 0, 0);
        cyc(0, 1, 1, 1, 6'h00, 6'h00, 0, 0);
        cyc(0, 1, 0, 0, 6'h05, 6'h1A, 0, 0);
        cyc(1, 1, 0, 0, 6'h05, 6'h1A, 0, 0);
        cyc(0, 1, 0, 0, 6'h05, 6'h1A, 0, 0);
        // 256 transfers wrap the counter back to 0.
        repeat (256) cyc(0, 1, 0, 1, 6'h05, 6'h00, 0, 0);
        cyc(0, 1, 1, 1, 6'h00, 6'h00, 0, 0);
        // Random traffic, with occasional long back-pressure bursts.
        for (int i = 0; i < 3000; i++) begin
            bit hold;
            hold = (i % 200) >= 170;
            cyc(($urandom % 150) == 0, ($urandom % 25) != 0,
                ($urandom % 4) == 0, ($urandom % 4) == 0,
                DW'($urandom), DW'($urandom),
                hold || (($urandom % 5) == 0), hold || (($urandom % 5) == 0));
        end
        repeat (2) @(negedge clk);
        #4;
        check("cycle_queue_drained", 32'(cq.size()), 32'd0);
        check("xfer_queue_drained", 32'(xq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vc_dest_arbiter.md
Name: vc_dest_arbiter

Overview:
- Scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the transaction layer.
- Each cycle it picks at most one VC head word, pops it and pushes it into the D FIFO selected by the word's destination bit.
- Round-robin between VCs; back-pressure from D almost-full flags; stall watchdog with sticky error.
- Gated by the transaction-layer FSM enable (ACTIVE state).

Parameters:
- DATA_W, 6, word width.
- DEST_BIT, 4, bit index of the destination select (0 → D0, 1 → D1).
- STALL_MAX, 15, consecutive blocked cycles before the error is raised.
- CNT_W, 8, width of the transfer counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- enable  in  1  transfer permission from transaction FSM.
- vc0_empty  in  1  VC0 FIFO empty.
- vc1_empty  in  1  VC1 FIFO empty.
- vc0_data  in  DATA_W  VC0 head word (first-word-fall-through).
- vc1_data  in  DATA_W  VC1 head word (first-word-fall-through).
- d0_almost_full  in  1  D0 at or above its full threshold.
- d1_almost_full  in  1  D1 at or above its full threshold.
- pop_vc0  out  1  pop VC0 this cycle.
- pop_vc1  out  1  pop VC1 this cycle.
- push_d0  out  1  push D0 this cycle.
- push_d1  out  1  push D1 this cycle.
- data_out  out  DATA_W  word written to D0/D1.
- active_out  out  1  transfer occurs this cycle.
- idle_out  out  1  enabled and both VCs empty.
- stall_err  out  1  sticky watchdog error.
- xfer_cnt  out  CNT_W  total transfers, wraps.

Behaviour:
- Eligibility: elig_i = enable & !vci_empty & !dY_almost_full, where Y = vci_data[DEST_BIT]. State must be RUN or STALLED; there is no eligibility in ERROR.
- Grant is combinational from current inputs and registered last_grant.
  - Only one VC eligible → that VC is granted.
  - Both eligible → grant the VC != last_grant.
  - Neither eligible → no grant.
- On grant g:
  - pop_vcg = 1.
  - push_dY = 1, with Y = dest bit of the granted word.
  - data_out = granted word.
  - All in the same cycle: zero-latency cut-through; the FIFOs update at the next edge.
- Outputs when no grant: pop/push = 0, data_out = 0. At most one pop and one push are high per cycle.
- Registered on each edge with a grant: last_grant ← g; xfer_cnt ← xfer_cnt + 1, modulo 2^CNT_W.
- FSM states:
  - DISABLED: enable = 0.
  - RUN.
  - STALLED: some VC non-empty but none eligible.
  - ERROR.
- FSM transitions:
  - DISABLED → RUN when enable = 1.
  - Any non-ERROR state → DISABLED when enable = 0.
  - RUN → STALLED when enable = 1, at least one VC non-empty, and no grant.
  - STALLED → RUN on any grant, or when both VCs are empty.
  - STALLED → ERROR when stall_cnt reaches STALL_MAX.
  - ERROR is left only by reset.
- stall_cnt:
  - Increments each cycle in STALLED, saturating.
  - Cleared on entry to RUN or DISABLED.
  - ERROR is entered on the edge where stall_cnt == STALL_MAX - 1 and the block is still stalled, so stall_err rises after exactly STALL_MAX blocked cycles.
- Output flags:
  - stall_err = (state == ERROR).
  - active_out = grant valid.
  - idle_out = enable & vc0_empty & vc1_empty & state != ERROR.
- Reset values: state DISABLED, last_grant = 1 (VC0 wins the first tie), stall_cnt = 0, xfer_cnt = 0, stall_err = 0. All combinational outputs are 0 while reset is high.
- Reset mid-transfer: pop/push are forced low in the reset cycle and no word is lost or duplicated.
- Enable drop: pop/push are deasserted in the same cycle enable falls. last_grant and xfer_cnt are retained.
- Almost-full asserted in the same cycle as a head targeting that FIFO: the head is blocked. The other VC may still be granted if its destination is free (no head-of-line coupling between VCs).

Decomposition:
- Shared transaction package holds:
  - FSM state encodings: one-hot DISABLED=4'b0001, RUN=4'b0010, STALLED=4'b0100, ERROR=4'b1000, matching the transaction FSM style.
  - DATA_W default.
  - DEST_BIT constant.
- One natural sub-module, rr_arb2: 2-requester round-robin with a last_grant register. The top block handles eligibility, routing, FSM and counters.

Test Plan:
- Reset, then enable = 1, VC0 head 6'h05 (dest 0), VC1 empty → same cycle pop_vc0 = 1, push_d0 = 1, data_out = 6'h05; xfer_cnt = 1 next cycle.
- Both VCs non-empty, dests D0 and D1 (no almost-full), 4 cycles → grants alternate VC0, VC1, VC0, VC1; xfer_cnt = 4.
- VC0 head targets D1 with d1_almost_full = 1; VC1 head targets D0 → only VC1 is granted each cycle; VC0 is never popped.
- Both heads target D0, d0_almost_full = 1 for 15 cycles → state STALLED; stall_err = 1 after the 15th blocked cycle; it stays high after almost-full clears until reset.
- enable falls mid-stream → pop/push = 0 that cycle. On re-enable, arbitration resumes with the retained last_grant.
- Preload xfer_cnt to 255 via transfers → the next transfer wraps xfer_cnt to 0. Reset asserted during a grant cycle → all outputs 0 and xfer_cnt = 0.
